pwm_sequencer: RTL
==================

Name: pwm_sequencer

Overview:
- Drives a PWM generator for the photonic switches by sequencing its A/B count values and its frame strobe.
- Holds a table of up to DEPTH (A,B) duty steps, which the host writes over a simple valid/ready port.
- Once started, it emits one frame strobe per frame_period cycles and presents the next step's A/B values one cycle before each strobe, so the counters load stable data.
- Supports one-shot and looping sequences, and a graceful stop that lets the current frame finish.

Parameters:
- W, 7, width of A/B count values.
- DEPTH, 8, number of sequence table entries (power of 2).
- AW, 3, table address width, log2(DEPTH).
- FW, 8, width of frame period counter.

Ports:
- clkCore  in  1  core clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- cfg_wr  in  1  table write valid.
- cfg_ready  out  1  table write ready; high only in IDLE.
- cfg_addr  in  AW  table entry index.
- cfg_a  in  W  A value for the entry.
- cfg_b  in  W  B value for the entry.
- seq_len  in  AW+1  number of active steps (1..DEPTH); sampled at start.
- frame_period  in  FW  cycles per frame; sampled at start.
- loop  in  1  1 = repeat the sequence; 0 = one-shot; sampled at start.
- start  in  1  one-cycle start request.
- stop  in  1  one-cycle stop request.
- frame_z  out  1  one-cycle frame strobe; drives the PWM counter reload.
- pwm_en  out  1  enable to the PWM counters.
- A_val  out  W  current A value.
- B_val  out  W  current B value.
- step_idx  out  AW  index of the step currently loaded.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when returning to IDLE.
- cfg_err  out  1  sticky error flag; cleared by an accepted start.

Behaviour:
- Reset (reset==0 at a clkCore edge), state after reset:
  - State goes to IDLE; all outputs 0 except cfg_ready=1.
  - Table contents are NOT cleared.
- Reset asserted mid-RUN aborts immediately; no done pulse.
- Table writes: a write completes when cfg_wr && cfg_ready, storing table[cfg_addr]={cfg_a,cfg_b}.
- cfg_wr while cfg_ready==0 is dropped and sets cfg_err.
- Start-time sampling:
  - P = max(frame_period, 2).
  - L = seq_len, clamped to DEPTH if larger.
  - loop is latched.
- start with L==0 is ignored and sets cfg_err.
- State machine: IDLE, LOAD, RUN, DRAIN.
- IDLE -> LOAD on an accepted start:
  - Latch P, L and loop; clear cfg_err.
  - A_val/B_val <= table[0]; step_idx <= 0; busy=1; cfg_ready=0.
- LOAD -> RUN after exactly 1 cycle:
  - frame_z=1 and pwm_en=1 in the first RUN cycle.
  - Frame counter fcnt <= P-1.
- RUN, per cycle, fcnt decrements.
- RUN, when fcnt==1 (the cycle before a strobe):
  - A_val/B_val <= table[next], where next = (step_idx+1) wraps to 0 at L.
  - In one-shot mode, if step_idx==L-1, A/B hold instead.
- RUN, when fcnt==0:
  - frame_z=1; fcnt <= P-1; step_idx <= next.
  - One-shot, last step finished: go IDLE, pwm_en=0, done=1, no frame_z.
- Strobe timing: frame_z asserts every P cycles exactly; A/B are stable ≥1 cycle before and during each frame_z.
- stop:
  - In RUN: go to DRAIN; the current frame completes; at fcnt==0 go IDLE with no frame_z, pwm_en=0, done=1.
  - In LOAD: deferred; DRAIN is entered at RUN entry.
  - In IDLE: ignored.
  - stop and start in the same IDLE cycle: start wins and stop is ignored.
- start while busy is ignored.
- L==1 with loop=1: A/B are constant and frame_z repeats every P cycles.
- DRAIN: A/B are not updated; a pending stop has priority over the fcnt==1 table fetch.
- step_idx always lies in 0..L-1.
- Arithmetic: table indices wrap modulo L; all counters are unsigned; no overflow (fcnt ≤ 2^FW-1).

Test Plan:
- Reset, write table[0..2]=(10,20),(30,40),(50,60), L=3, P=5, loop=0, start -> frame_z at RUN cycles 0,5,10; A/B switch to (30,40) at cycle 4 and (50,60) at cycle 9; IDLE and done at cycle 15; step_idx sequence 0,1,2.
- Same table, loop=1, P=2 -> frame_z every 2nd cycle; A/B sequence 10,30,50,10,... repeats; busy stays 1.
- loop=1 run, stop pulse at RUN cycle 7 with P=5 -> no more table fetch; done at cycle 10; no frame_z at cycle 10; pwm_en=0 from cycle 10.
- frame_period=0 or 1 -> period forced to 2; seq_len=0 start -> stays IDLE and cfg_err=1; next valid start clears cfg_err.
- cfg_wr during RUN -> table unchanged (read back on next run), cfg_err=1.
- reset driven low at RUN cycle 3 -> next edge: all outputs 0, cfg_ready=1, no done; table preserved and reused on restart.

Source files
------------

// File: rtl/pwm_sequencer.sv
// Steps a PWM generator through a host-programmed table of (A,B) duty values.
// Each frame is framed by a one-cycle strobe. A/B settle one cycle before that strobe.
module pwm_sequencer #(
  parameter int unsigned W     = 7,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned FW    = 8
) (
  input  logic            clkCore,
  input  logic            reset,
  input  logic            cfg_wr,
  output logic            cfg_ready,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [W-1:0]    cfg_a,
  input  logic [W-1:0]    cfg_b,
  input  logic [AW:0]     seq_len,
  input  logic [FW-1:0]   frame_period,
  input  logic            loop,
  input  logic            start,
  input  logic            stop,
  output logic            frame_z,
  output logic            pwm_en,
  output logic [W-1:0]    A_val,
  output logic [W-1:0]    B_val,
  output logic [AW-1:0]   step_idx,
  output logic            busy,
  output logic            done,
  output logic            cfg_err
);

  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t          state;
  logic [2*W-1:0]  tbl [DEPTH];
  logic [LW-1:0]   len_q;
  logic [FW-1:0]   per_q;
  logic [FW-1:0]   fcnt;
  logic            loop_q;

  logic [LW-1:0]   len_clamp;
  logic [FW-1:0]   per_clamp;
  logic [LW-1:0]   idx_inc;
  logic [AW-1:0]   next_idx;
  logic            last_step;
  logic            hold_ab;

  // Start-time operand conditioning and next-step arithmetic (indices wrap at L)
  assign len_clamp = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
  assign per_clamp = (frame_period < FW'(2)) ? FW'(2) : frame_period;
  assign idx_inc   = {1'b0, step_idx} + LW'(1);
  assign next_idx  = (idx_inc >= len_q) ? '0 : idx_inc[AW-1:0];
  assign last_step = (idx_inc >= len_q);
  assign hold_ab   = !loop_q && last_step;

  // Table storage survives reset; writes only land while the sequencer is idle
  always_ff @(posedge clkCore) begin
    if (reset && cfg_wr && cfg_ready) begin
      tbl[cfg_addr] <= {cfg_a, cfg_b};
    end
  end

  always_ff @(posedge clkCore) begin
    if (!reset) begin
      state     <= IDLE;
      cfg_ready <= 1'b1;
      frame_z   <= 1'b0;
      pwm_en    <= 1'b0;
      A_val     <= '0;
      B_val     <= '0;
      step_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      len_q     <= '0;
      per_q     <= '0;
      fcnt      <= '0;
      loop_q    <= 1'b0;
    end else begin
      frame_z <= 1'b0;
      done    <= 1'b0;
      if (cfg_wr && !cfg_ready) begin
        cfg_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (len_clamp == '0) begin
              cfg_err <= 1'b1;
            end else begin
              state            <= LOAD;
              len_q            <= len_clamp;
              per_q            <= per_clamp;
              loop_q           <= loop;
              cfg_err          <= 1'b0;
              {A_val, B_val}   <= tbl[AW'(0)];
              step_idx         <= '0;
              busy             <= 1'b1;
              cfg_ready        <= 1'b0;
            end
          end
        end

        // A stop seen during LOAD sends the first frame straight into DRAIN
        LOAD: begin
          state   <= stop ? DRAIN : RUN;
          frame_z <= 1'b1;
          pwm_en  <= 1'b1;
          fcnt    <= per_q - FW'(1);
        end

        RUN: begin
          if (fcnt == '0) begin
            if (stop || hold_ab) begin
              state     <= IDLE;
              pwm_en    <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              cfg_ready <= 1'b1;
            end else begin
              frame_z  <= 1'b1;
              fcnt     <= per_q - FW'(1);
              step_idx <= next_idx;
            end
          end else begin
            fcnt <= fcnt - FW'(1);
            if (stop) begin
              state <= DRAIN;
            end else if (fcnt == FW'(1) && !hold_ab) begin
              {A_val, B_val} <= tbl[next_idx];
            end
          end
        end

        DRAIN: begin
          if (fcnt == '0) begin
            state     <= IDLE;
            pwm_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            cfg_ready <= 1'b1;
          end else begin
            fcnt <= fcnt - FW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
